// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   CNT_W          : width of the big-endian word count in the frame header
//   BYTES_PER_WORD : bytes packed into one instruction word
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    FLUSH,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
// Packs accepted bytes into big-endian 32-bit words. The first byte of a word
// lands in [31:24], the last in [7:0]. The completed word is presented with a
// one-cycle word_valid strobe in the cycle after its fourth byte is accepted.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (cancels a pending word)
//   clear      in   discard any partial word (byte counter back to 0)
//   byte_valid in   a byte is being accepted this cycle
//   byte_data  in   the accepted byte
//   word_last  out  the next accepted byte completes a word
//   word_valid out  one-cycle strobe: word holds a freshly completed word
//   word       out  last completed word (0 after reset)
// -----------------------------------------------------------------------------
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  // Holds the first three bytes of the word in progress; lane 0 is the newest.
  logic [BYTES_PER_WORD-2:0][7:0] lane_reg;
  logic [1:0]                     cnt_reg;

  assign word_last = (cnt_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg   <= '0;
      cnt_reg    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt_reg <= '0;
      end else if (byte_valid) begin
        lane_reg <= {lane_reg[BYTES_PER_WORD-3:0], byte_data};
        // Counter wraps from 3 back to 0 as a word completes.
        cnt_reg  <= cnt_reg + 2'd1;
        if (word_last) begin
          word_valid <= 1'b1;
          word       <= {lane_reg, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Byte-stream boot loader. Receives a framed byte stream
//   CNT_HI, CNT_LO (N, big-endian), 4*N data bytes [, checksum byte]
// packs the data into big-endian words, writes them to the instruction memory
// at BASE_ADDR + 4*idx and holds the core in reset until the image is in.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   : a checksum byte c follows the data; (sum of data + c) mod 256
//               must be 0, otherwise the frame is rejected. Also required for N=0.
//   undefined : no checksum byte; the last data byte ends the frame.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse: restart framing from any state
//   in_valid   in   input byte valid
//   in_data    in   input byte
//   in_ready   out  loader accepts a byte (transfer = in_valid & in_ready)
//   wr_en      out  one-cycle instruction-memory write strobe
//   wr_addr    out  byte address of the word being written
//   wr_data    out  word being written (first received byte in [31:24])
//   cpu_hold   out  1 = core held in reset
//   load_done  out  image loaded and accepted
//   load_err   out  frame rejected
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
  parameter int unsigned         MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = FLUSH;
`endif

  state_t            state_reg, state_next;
  logic [7:0]        cnt_hi_reg;
  logic [CNT_W-1:0]  n_words_reg;
  logic [CNT_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] wr_addr_reg;

  logic              accept;
  logic              data_accept;
  logic              word_last;
  logic              last_word;
  logic [CNT_W-1:0]  hdr_n;

  // start has priority: a byte offered in the same cycle is not taken.
  assign accept      = in_valid & in_ready & ~start;
  assign data_accept = accept & (state_reg == DATA);
  assign hdr_n       = {cnt_hi_reg, in_data};
  assign last_word   = (idx_reg == n_words_reg - CNT_W'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic [7:0] csum_total;
  assign csum_total = sum_reg + in_data;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HDR0;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;

    case (state_reg)
      HDR0, HDR1, DATA, CSUM: in_ready = 1'b1;
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      ERR:     load_err = 1'b1;
      default: ;
    endcase

    if (start) begin
      state_next = HDR0;
    end else begin
      case (state_reg)
        HDR0: if (accept) state_next = HDR1;
        HDR1: begin
          if (accept) begin
            if (hdr_n == '0) begin
              state_next = AFTER_DATA;
            end else if (hdr_n > MAX_N) begin
              state_next = ERR;
            end else begin
              state_next = DATA;
            end
          end
        end
        DATA: if (accept && word_last && last_word) state_next = AFTER_DATA;
        CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) state_next = (csum_total == 8'd0) ? FLUSH : ERR;
`else
          state_next = FLUSH;
`endif
        end
        // One idle cycle keeps cpu_hold high past the final write strobe.
        FLUSH:   state_next = DONE;
        DONE:    state_next = DONE;
        ERR:     state_next = ERR;
        default: state_next = HDR0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Header capture, word index, address generation, checksum accumulation
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi_reg  <= '0;
      n_words_reg <= '0;
      idx_reg     <= '0;
      wr_addr_reg <= BASE_ADDR;
    end else if (start) begin
      idx_reg     <= '0;
      wr_addr_reg <= BASE_ADDR;
    end else begin
      if (accept && state_reg == HDR0) begin
        cnt_hi_reg <= in_data;
      end
      if (accept && state_reg == HDR1) begin
        n_words_reg <= hdr_n;
        idx_reg     <= '0;
      end
      // Address is registered alongside the packer's word so both appear
      // together in the write-strobe cycle.
      if (data_accept && word_last) begin
        wr_addr_reg <= BASE_ADDR + (ADDR_W'(idx_reg) << 2);
        idx_reg     <= idx_reg + CNT_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sum_reg <= '0;
    end else if (accept && state_reg == HDR1) begin
      sum_reg <= '0;
    end else if (data_accept) begin
      sum_reg <= sum_reg + in_data;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Byte-to-word packer
  // ---------------------------------------------------------------------------
  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_valid (data_accept),
    .byte_data  (in_data),
    .word_last  (word_last),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  assign wr_addr = wr_addr_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected memory writes are derived
// from each frame's byte list and queued when the frame is issued; a monitor
// pops and compares them whenever wr_en is seen. Status outputs are checked
// at fixed cycle offsets from the final accepted byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MAX_WORDS = 256;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int vectors    = 0;
  int miscompares = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write (t=%0t)",
                 wr_addr, wr_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        $display("write addr=%h data=%h", wr_addr, wr_data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // gap < 0 : random 0..2 idle cycles before the byte, else exactly gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    idle((gap < 0) ? $urandom_range(0, 2) : gap);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    chk("in_ready_accepting", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_hold"},  cpu_hold, 1);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_wr_en"},     wr_en, 0);
    chk({tag, "_wr_addr"},   wr_addr, 32'h0);
    chk({tag, "_wr_data"},   wr_data, 32'h0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_load_err"},  load_err, 0);
  endtask

  task automatic pulse_start(input bit with_byte, input logic [7:0] b);
    start    = 1'b1;
    in_valid = with_byte;
    in_data  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("start_cpu_hold",  cpu_hold, 1);
    chk("start_load_done", load_done, 0);
    chk("start_load_err",  load_err, 0);
    chk("start_in_ready",  in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Issue one complete frame and check the resulting status.
  task automatic run_frame(input int n, input logic [7:0] data[$], input int gap,
                           input bit bad_csum);
    wr_t        w;
    logic [7:0] sum;
    logic [7:0] c;
    bit         ok;
    ok  = !(CSUM_EN && bad_csum);
    sum = 8'h00;
    c   = 8'h00;
    if (n <= MAX_WORDS) begin
      for (int i = 0; i < n; i++) begin
        w.addr = 32'(4 * i);
        w.data = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
        exp_q.push_back(w);
      end
    end
    $display("frame n=%0d gap=%0d bad_csum=%0d", n, gap, bad_csum);
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    if (n > MAX_WORDS) begin
      @(negedge clk);
      chk("oversize_load_err",  load_err, 1);
      chk("oversize_cpu_hold",  cpu_hold, 1);
      chk("oversize_in_ready",  in_ready, 0);
      chk("oversize_load_done", load_done, 0);
      @(posedge clk);
      #1;
      return;
    end
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(data[i], gap);
      sum = sum + data[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("csum_wait_done", load_done, 0);
    chk("csum_wait_hold", cpu_hold, 1);
    @(posedge clk);
    #1;
    c = 8'h00 - sum;
    if (bad_csum) c = c + 8'h01;
    send_byte(c, gap);
`endif
    @(negedge clk);
    if (ok) begin
      chk("flush_cpu_hold",  cpu_hold, 1);
      chk("flush_load_done", load_done, 0);
    end else begin
      chk("csum_load_err",   load_err, 1);
      chk("csum_cpu_hold",   cpu_hold, 1);
    end
    chk("end_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    if (ok) begin
      chk("done_cpu_hold",  cpu_hold, 0);
      chk("done_load_done", load_done, 1);
      chk("done_load_err",  load_err, 0);
    end else begin
      chk("err_load_err",   load_err, 1);
      chk("err_cpu_hold",   cpu_hold, 1);
      chk("err_load_done",  load_done, 0);
    end
    chk("writes_drained", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d[$];
    int n;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;

    // Two-word image, back to back.
    d = {8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01};
    run_frame(2, d, 0, 1'b0);

    // Bytes after the frame are refused and produce no writes.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("extra_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Empty image.
    pulse_start(1'b0, 8'h00);
    d = {};
    run_frame(0, d, 0, 1'b0);

    // Oversize header (257 words).
    pulse_start(1'b0, 8'h00);
    run_frame(257, d, 0, 1'b0);

    // One word with in_valid toggling every other cycle.
    pulse_start(1'b0, 8'h00);
    d = {8'hE0, 8'h00, 8'h00, 8'h00};
    run_frame(1, d, 1, 1'b0);

    // Abort mid-word; the byte offered alongside start must be dropped.
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hE0, 0);
    send_byte(8'h00, 0);
    pulse_start(1'b1, 8'h55);
    d = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(1, d, 0, 1'b0);

    // Bad checksum (plain frame when the checksum is not built in).
    pulse_start(1'b0, 8'h00);
    d = {8'hE0, 8'h00, 8'h00, 8'h00};
    run_frame(1, d, 0, 1'b1);

    // Largest accepted image.
    pulse_start(1'b0, 8'h00);
    d = {};
    for (int i = 0; i < 4 * MAX_WORDS; i++) d.push_back(8'($urandom));
    run_frame(MAX_WORDS, d, 0, 1'b0);

    // Random frames.
    for (int f = 0; f < 20; f++) begin
      pulse_start(1'b0, 8'h00);
      n = ($urandom_range(0, 9) == 0) ? MAX_WORDS + 1 + $urandom_range(0, 300)
                                       : $urandom_range(0, 6);
      d = {};
      if (n <= MAX_WORDS) begin
        for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
      end
      run_frame(n, d, ($urandom_range(0, 1) == 0) ? 0 : -1, ($urandom_range(0, 3) == 0));
    end

    // Reset coinciding with the fourth byte of a word cancels its write.
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h78;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midframe_rst");
    @(posedge clk);
    #1;
    d = {8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_frame(1, d, 0, 1'b0);

    idle(3);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
